// File: rtl/retry_pkg.sv
// Shared types and defaults for the link-layer local retry state machine.
package retry_pkg;

  localparam int unsigned LRSM_NUM_W = 5;
  localparam int unsigned LRSM_TMO_W = 13;
  localparam logic [3:0]  LRSM_PL_ACTIVE = 4'h1;

  typedef enum logic [3:0] {
    ST_NORMAL     = 4'd0,
    ST_LLRREQ     = 4'd1,
    ST_IDLE       = 4'd2,
    ST_PHY_REINIT = 4'd3,
    ST_ABORT      = 4'd4
  } lrsm_state_e;

endpackage

// File: rtl/retry_timeout_cnt.sv
// Saturating retry timeout counter with clear and a registered "== limit" flag.
module retry_timeout_cnt #(
  parameter int unsigned W = 13
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] limit_i,
  output logic         at_limit_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         at_limit_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !(&cnt_q)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Flag tracks the value the counter holds after this edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      at_limit_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      at_limit_q <= (cnt_d == limit_i);
    end
  end

  assign at_limit_o = at_limit_q;

endmodule

// File: rtl/retry_lrsm.sv
// Local Retry State Machine: sequences RETRY.Req, timeout re-requests,
// physical-layer re-init escalation and terminal link failure.
module retry_lrsm_ctrl
  import retry_pkg::*;
#(
  parameter int unsigned NUM_W     = LRSM_NUM_W,
  parameter int unsigned TMO_W     = LRSM_TMO_W,
  parameter logic [3:0]  PL_ACTIVE = LRSM_PL_ACTIVE
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pl_lnk_up,
  input  logic [3:0]       i_pl_state_sts,
  input  logic             unpacker_valid_sig,
  input  logic             unpacker_valid_crc,
  input  logic             unpacker_ack_seq_flag,
  input  logic             controller_req_sent_flag,
  input  logic             controller_inc_time_out_retry,
  input  logic [NUM_W-1:0] i_register_file_retry_threshold,
  input  logic [NUM_W-1:0] i_register_file_reinit_threshold,
  input  logic [TMO_W-1:0] i_register_file_retry_timeout_max_transfers,
  output logic             retry_send_req_seq,
  output logic             retry_phy_reinit_req,
  output logic             retry_link_failure_sig,
  output logic             retry_stop_read,
  output logic             retry_exist_retry_state,
  output logic [NUM_W-1:0] retry_num_retry,
  output logic [NUM_W-1:0] retry_num_phy_reinit,
  output logic             Retry_Threshold_hit,
  output logic             REINIT_Threshold_hit,
  output logic [3:0]       LRSM
);

  lrsm_state_e      state_q, state_d;
  logic [NUM_W-1:0] num_retry_q, num_retry_d;
  logic [NUM_W-1:0] num_reinit_q, num_reinit_d;
  logic             down_seen_q, down_seen_d;
  logic             req_q, req_d;
  logic             phy_q, phy_d;
  logic             fail_q, fail_d;
  logic             stop_q, stop_d;
  logic             exist_q, exist_d;
  logic             rth_q, rth_d;
  logic             ith_q, ith_d;
  logic             tmo_clr;
  logic             tmo_inc;
  logic             tmo_hit;
  logic             crc_err;
  logic             retry_at_thr;

  assign crc_err      = unpacker_valid_sig & ~unpacker_valid_crc;
  assign retry_at_thr = (num_retry_q == i_register_file_retry_threshold);
  assign tmo_inc      = (state_q == ST_IDLE) & controller_inc_time_out_retry;

  retry_timeout_cnt #(
    .W (TMO_W)
  ) u_tmo (
    .clk_i      (i_clk),
    .rst_i      (i_rst),
    .clr_i      (tmo_clr),
    .inc_i      (tmo_inc),
    .limit_i    (i_register_file_retry_timeout_max_transfers),
    .at_limit_o (tmo_hit)
  );

  // Next-state, counter updates and threshold pulses.
  always_comb begin
    state_d      = state_q;
    num_retry_d  = num_retry_q;
    num_reinit_d = num_reinit_q;
    down_seen_d  = down_seen_q;
    rth_d        = 1'b0;
    ith_d        = 1'b0;
    tmo_clr      = 1'b0;
    case (state_q)
      ST_NORMAL: begin
        if (crc_err) state_d = ST_LLRREQ;
      end
      ST_LLRREQ: begin
        if (retry_at_thr && (num_reinit_q == i_register_file_reinit_threshold)) begin
          state_d = ST_ABORT;
          ith_d   = 1'b1;
        end else if (retry_at_thr) begin
          state_d      = ST_PHY_REINIT;
          rth_d        = 1'b1;
          num_retry_d  = '0;
          num_reinit_d = (&num_reinit_q) ? num_reinit_q : num_reinit_q + NUM_W'(1);
          down_seen_d  = 1'b0;
        end else if (controller_req_sent_flag) begin
          state_d     = ST_IDLE;
          tmo_clr     = 1'b1;
          num_retry_d = (&num_retry_q) ? num_retry_q : num_retry_q + NUM_W'(1);
        end
      end
      ST_IDLE: begin
        if (unpacker_ack_seq_flag) begin
          state_d      = ST_NORMAL;
          num_retry_d  = '0;
          num_reinit_d = '0;
        end else if (tmo_hit) begin
          state_d = ST_LLRREQ;
        end
      end
      ST_PHY_REINIT: begin
        // Exit only after a link drop followed by a return to Active.
        if (!i_pl_lnk_up) begin
          down_seen_d = 1'b1;
        end else if (down_seen_q && (i_pl_state_sts == PL_ACTIVE)) begin
          state_d = ST_LLRREQ;
        end
      end
      ST_ABORT: begin
        state_d = ST_ABORT;
      end
      default: begin
        state_d = ST_NORMAL;
      end
    endcase
  end

  // Outputs are decoded from next-state values so they register alongside the state.
  always_comb begin
    req_d   = (state_d == ST_LLRREQ) && (num_retry_d != i_register_file_retry_threshold);
    phy_d   = (state_d == ST_PHY_REINIT);
    fail_d  = (state_d == ST_ABORT);
    stop_d  = (state_d == ST_LLRREQ) || (state_d == ST_IDLE) || (state_d == ST_PHY_REINIT);
    exist_d = (state_d != ST_NORMAL);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_NORMAL;
      num_retry_q  <= '0;
      num_reinit_q <= '0;
      down_seen_q  <= 1'b0;
      req_q        <= 1'b0;
      phy_q        <= 1'b0;
      fail_q       <= 1'b0;
      stop_q       <= 1'b0;
      exist_q      <= 1'b0;
      rth_q        <= 1'b0;
      ith_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      num_retry_q  <= num_retry_d;
      num_reinit_q <= num_reinit_d;
      down_seen_q  <= down_seen_d;
      req_q        <= req_d;
      phy_q        <= phy_d;
      fail_q       <= fail_d;
      stop_q       <= stop_d;
      exist_q      <= exist_d;
      rth_q        <= rth_d;
      ith_q        <= ith_d;
    end
  end

  assign retry_send_req_seq      = req_q;
  assign retry_phy_reinit_req    = phy_q;
  assign retry_link_failure_sig  = fail_q;
  assign retry_stop_read         = stop_q;
  assign retry_exist_retry_state = exist_q;
  assign retry_num_retry         = num_retry_q;
  assign retry_num_phy_reinit    = num_reinit_q;
  assign Retry_Threshold_hit     = rth_q;
  assign REINIT_Threshold_hit    = ith_q;
  assign LRSM                    = 4'(state_q);

endmodule

// File: tb/tb_retry_lrsm_ctrl.sv
// Scenario bench for retry_lrsm_ctrl: per-cycle expected outputs are queued
// as stimulus is driven and compared after each clock edge.
module tb_retry_lrsm_ctrl;

  localparam int unsigned NUM_W = 5;
  localparam int unsigned TMO_W = 13;

  // Stimulus bits for one cycle.
  localparam int unsigned NOP  = 0;
  localparam int unsigned CRC  = 1;
  localparam int unsigned GOOD = 2;
  localparam int unsigned ACK  = 4;
  localparam int unsigned SENT = 8;
  localparam int unsigned TICK = 16;
  localparam int unsigned LDN  = 32;
  localparam int unsigned STSX = 64;
  localparam int unsigned RST  = 128;

  typedef struct packed {
    logic [3:0]       lrsm;
    logic             req;
    logic             phy;
    logic             fail;
    logic             stop;
    logic             exist;
    logic [NUM_W-1:0] nr;
    logic [NUM_W-1:0] np;
    logic             rth;
    logic             ith;
  } out_t;

  typedef struct {
    int unsigned ins;
    out_t        e;
  } step_t;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_pl_lnk_up;
  logic [3:0]       i_pl_state_sts;
  logic             unpacker_valid_sig;
  logic             unpacker_valid_crc;
  logic             unpacker_ack_seq_flag;
  logic             controller_req_sent_flag;
  logic             controller_inc_time_out_retry;
  logic [NUM_W-1:0] rthr;
  logic [NUM_W-1:0] ithr;
  logic [TMO_W-1:0] tmax;
  logic             retry_send_req_seq;
  logic             retry_phy_reinit_req;
  logic             retry_link_failure_sig;
  logic             retry_stop_read;
  logic             retry_exist_retry_state;
  logic [NUM_W-1:0] retry_num_retry;
  logic [NUM_W-1:0] retry_num_phy_reinit;
  logic             Retry_Threshold_hit;
  logic             REINIT_Threshold_hit;
  logic [3:0]       LRSM;

  out_t obs;
  out_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 i_clk = ~i_clk;

  retry_lrsm_ctrl #(
    .NUM_W     (NUM_W),
    .TMO_W     (TMO_W),
    .PL_ACTIVE (4'h1)
  ) dut (
    .i_clk                                       (i_clk),
    .i_rst                                       (i_rst),
    .i_pl_lnk_up                                 (i_pl_lnk_up),
    .i_pl_state_sts                              (i_pl_state_sts),
    .unpacker_valid_sig                          (unpacker_valid_sig),
    .unpacker_valid_crc                          (unpacker_valid_crc),
    .unpacker_ack_seq_flag                       (unpacker_ack_seq_flag),
    .controller_req_sent_flag                    (controller_req_sent_flag),
    .controller_inc_time_out_retry               (controller_inc_time_out_retry),
    .i_register_file_retry_threshold             (rthr),
    .i_register_file_reinit_threshold            (ithr),
    .i_register_file_retry_timeout_max_transfers (tmax),
    .retry_send_req_seq                          (retry_send_req_seq),
    .retry_phy_reinit_req                        (retry_phy_reinit_req),
    .retry_link_failure_sig                      (retry_link_failure_sig),
    .retry_stop_read                             (retry_stop_read),
    .retry_exist_retry_state                     (retry_exist_retry_state),
    .retry_num_retry                             (retry_num_retry),
    .retry_num_phy_reinit                        (retry_num_phy_reinit),
    .Retry_Threshold_hit                         (Retry_Threshold_hit),
    .REINIT_Threshold_hit                        (REINIT_Threshold_hit),
    .LRSM                                        (LRSM)
  );

  assign obs = {LRSM, retry_send_req_seq, retry_phy_reinit_req, retry_link_failure_sig,
                retry_stop_read, retry_exist_retry_state, retry_num_retry,
                retry_num_phy_reinit, Retry_Threshold_hit, REINIT_Threshold_hit};

  // Expected outputs; failure/stop/exist follow from the state code.
  function automatic out_t mk(input int s, input int req, input int phy, input int nr,
                              input int np, input int rth, input int ith);
    out_t o;
    o.lrsm  = 4'(s);
    o.req   = 1'(req);
    o.phy   = 1'(phy);
    o.fail  = (s == 4);
    o.stop  = (s == 1) || (s == 2) || (s == 3);
    o.exist = (s != 0);
    o.nr    = NUM_W'(nr);
    o.np    = NUM_W'(np);
    o.rth   = 1'(rth);
    o.ith   = 1'(ith);
    return o;
  endfunction

  function automatic step_t st(input int unsigned ins, input out_t e);
    step_t s;
    s.ins = ins;
    s.e   = e;
    return s;
  endfunction

  // Drive one cycle of stimulus and sample just after the rising edge.
  task automatic cyc(input int unsigned ins);
    @(negedge i_clk);
    i_rst                         = (ins & RST) != 0;
    unpacker_valid_sig            = (ins & (CRC | GOOD)) != 0;
    unpacker_valid_crc            = (ins & GOOD) != 0;
    unpacker_ack_seq_flag         = (ins & ACK) != 0;
    controller_req_sent_flag      = (ins & SENT) != 0;
    controller_inc_time_out_retry = (ins & TICK) != 0;
    i_pl_lnk_up                   = (ins & LDN) == 0;
    i_pl_state_sts                = ((ins & STSX) != 0) ? 4'h2 : 4'h1;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    step_t s[$];
    s.push_back(st(RST,       mk(0, 0, 0, 0, 0, 0, 0)));
    s.push_back(st(RST | CRC, mk(0, 0, 0, 0, 0, 0, 0)));
    s.push_back(st(GOOD,      mk(0, 0, 0, 0, 0, 0, 0)));
    foreach (s[i]) begin
      out_t e;
      exp_q.push_back(s[i].e);
      cyc(s[i].ins);
      e = exp_q.pop_front();
      n_chk++;
      if (obs === e) n_pass++;
      else $display("FAIL reset step %0d: got %h expected %h", i, obs, e);
    end
  endtask

  task automatic test_normal_retry();
    step_t s[$];
    rthr = 5'd4; ithr = 5'd2; tmax = 13'd8;
    s.push_back(st(CRC,  mk(1, 1, 0, 0, 0, 0, 0)));
    s.push_back(st(NOP,  mk(1, 1, 0, 0, 0, 0, 0)));
    s.push_back(st(SENT, mk(2, 0, 0, 1, 0, 0, 0)));
    for (int k = 0; k < 3; k++) s.push_back(st(TICK, mk(2, 0, 0, 1, 0, 0, 0)));
    s.push_back(st(ACK,  mk(0, 0, 0, 0, 0, 0, 0)));
    s.push_back(st(ACK,  mk(0, 0, 0, 0, 0, 0, 0)));
    foreach (s[i]) begin
      out_t e;
      exp_q.push_back(s[i].e);
      cyc(s[i].ins);
      e = exp_q.pop_front();
      n_chk++;
      if (obs === e) n_pass++;
      else $display("FAIL normal_retry step %0d: got %h expected %h", i, obs, e);
    end
  endtask

  task automatic test_timeout_rerequest();
    step_t s[$];
    tmax = 13'd3;
    s.push_back(st(CRC,  mk(1, 1, 0, 0, 0, 0, 0)));
    s.push_back(st(SENT, mk(2, 0, 0, 1, 0, 0, 0)));
    for (int k = 0; k < 3; k++) s.push_back(st(TICK, mk(2, 0, 0, 1, 0, 0, 0)));
    s.push_back(st(NOP,  mk(1, 1, 0, 1, 0, 0, 0)));
    s.push_back(st(SENT, mk(2, 0, 0, 2, 0, 0, 0)));
    s.push_back(st(CRC,  mk(2, 0, 0, 2, 0, 0, 0)));
    s.push_back(st(ACK,  mk(0, 0, 0, 0, 0, 0, 0)));
    foreach (s[i]) begin
      out_t e;
      exp_q.push_back(s[i].e);
      cyc(s[i].ins);
      e = exp_q.pop_front();
      n_chk++;
      if (obs === e) n_pass++;
      else $display("FAIL timeout_rerequest step %0d: got %h expected %h", i, obs, e);
    end
  endtask

  task automatic test_escalation_abort();
    step_t s[$];
    rthr = 5'd2; ithr = 5'd1; tmax = 13'd3;
    s.push_back(st(CRC,  mk(1, 1, 0, 0, 0, 0, 0)));
    s.push_back(st(SENT, mk(2, 0, 0, 1, 0, 0, 0)));
    for (int k = 0; k < 3; k++) s.push_back(st(TICK, mk(2, 0, 0, 1, 0, 0, 0)));
    s.push_back(st(NOP,  mk(1, 1, 0, 1, 0, 0, 0)));
    s.push_back(st(SENT, mk(2, 0, 0, 2, 0, 0, 0)));
    for (int k = 0; k < 3; k++) s.push_back(st(TICK, mk(2, 0, 0, 2, 0, 0, 0)));
    s.push_back(st(NOP,  mk(1, 0, 0, 2, 0, 0, 0)));
    s.push_back(st(NOP,  mk(3, 0, 1, 0, 1, 1, 0)));
    s.push_back(st(NOP,  mk(3, 0, 1, 0, 1, 0, 0)));
    s.push_back(st(LDN,  mk(3, 0, 1, 0, 1, 0, 0)));
    s.push_back(st(STSX, mk(3, 0, 1, 0, 1, 0, 0)));
    s.push_back(st(NOP,  mk(1, 1, 0, 0, 1, 0, 0)));
    // Second round of timeouts exhausts both budgets.
    s.push_back(st(SENT, mk(2, 0, 0, 1, 1, 0, 0)));
    for (int k = 0; k < 3; k++) s.push_back(st(TICK, mk(2, 0, 0, 1, 1, 0, 0)));
    s.push_back(st(NOP,  mk(1, 1, 0, 1, 1, 0, 0)));
    s.push_back(st(SENT, mk(2, 0, 0, 2, 1, 0, 0)));
    for (int k = 0; k < 3; k++) s.push_back(st(TICK, mk(2, 0, 0, 2, 1, 0, 0)));
    s.push_back(st(NOP,  mk(1, 0, 0, 2, 1, 0, 0)));
    s.push_back(st(NOP,  mk(4, 0, 0, 2, 1, 0, 1)));
    s.push_back(st(ACK,  mk(4, 0, 0, 2, 1, 0, 0)));
    s.push_back(st(CRC,  mk(4, 0, 0, 2, 1, 0, 0)));
    s.push_back(st(RST,  mk(0, 0, 0, 0, 0, 0, 0)));
    foreach (s[i]) begin
      out_t e;
      exp_q.push_back(s[i].e);
      cyc(s[i].ins);
      e = exp_q.pop_front();
      n_chk++;
      if (obs === e) n_pass++;
      else $display("FAIL escalation_abort step %0d: got %h expected %h", i, obs, e);
    end
  endtask

  task automatic test_ack_vs_timeout();
    step_t s[$];
    rthr = 5'd4; ithr = 5'd2; tmax = 13'd3;
    s.push_back(st(CRC,  mk(1, 1, 0, 0, 0, 0, 0)));
    s.push_back(st(SENT, mk(2, 0, 0, 1, 0, 0, 0)));
    for (int k = 0; k < 3; k++) s.push_back(st(TICK, mk(2, 0, 0, 1, 0, 0, 0)));
    s.push_back(st(ACK | TICK, mk(0, 0, 0, 0, 0, 0, 0)));
    s.push_back(st(NOP,  mk(0, 0, 0, 0, 0, 0, 0)));
    foreach (s[i]) begin
      out_t e;
      exp_q.push_back(s[i].e);
      cyc(s[i].ins);
      e = exp_q.pop_front();
      n_chk++;
      if (obs === e) n_pass++;
      else $display("FAIL ack_vs_timeout step %0d: got %h expected %h", i, obs, e);
    end
  endtask

  task automatic test_reset_mid_reinit();
    step_t s[$];
    rthr = 5'd0; ithr = 5'd1;
    s.push_back(st(CRC, mk(1, 0, 0, 0, 0, 0, 0)));
    s.push_back(st(NOP, mk(3, 0, 1, 0, 1, 1, 0)));
    s.push_back(st(LDN, mk(3, 0, 1, 0, 1, 0, 0)));
    s.push_back(st(RST, mk(0, 0, 0, 0, 0, 0, 0)));
    s.push_back(st(CRC, mk(1, 0, 0, 0, 0, 0, 0)));
    s.push_back(st(NOP, mk(3, 0, 1, 0, 1, 1, 0)));
    for (int k = 0; k < 3; k++) s.push_back(st(NOP, mk(3, 0, 1, 0, 1, 0, 0)));
    s.push_back(st(LDN, mk(3, 0, 1, 0, 1, 0, 0)));
    s.push_back(st(NOP, mk(1, 0, 0, 0, 1, 0, 0)));
    s.push_back(st(NOP, mk(4, 0, 0, 0, 1, 0, 1)));
    s.push_back(st(RST, mk(0, 0, 0, 0, 0, 0, 0)));
    foreach (s[i]) begin
      out_t e;
      exp_q.push_back(s[i].e);
      cyc(s[i].ins);
      e = exp_q.pop_front();
      n_chk++;
      if (obs === e) n_pass++;
      else $display("FAIL reset_mid_reinit step %0d: got %h expected %h", i, obs, e);
    end
  endtask

  task automatic test_zero_thresholds();
    step_t s[$];
    rthr = 5'd0; ithr = 5'd0;
    s.push_back(st(CRC, mk(1, 0, 0, 0, 0, 0, 0)));
    s.push_back(st(NOP, mk(4, 0, 0, 0, 0, 0, 1)));
    s.push_back(st(NOP, mk(4, 0, 0, 0, 0, 0, 0)));
    s.push_back(st(RST, mk(0, 0, 0, 0, 0, 0, 0)));
    foreach (s[i]) begin
      out_t e;
      exp_q.push_back(s[i].e);
      cyc(s[i].ins);
      e = exp_q.pop_front();
      n_chk++;
      if (obs === e) n_pass++;
      else $display("FAIL zero_thresholds step %0d: got %h expected %h", i, obs, e);
    end
  endtask

  initial begin
    i_rst                         = 1'b1;
    i_pl_lnk_up                   = 1'b1;
    i_pl_state_sts                = 4'h1;
    unpacker_valid_sig            = 1'b0;
    unpacker_valid_crc            = 1'b0;
    unpacker_ack_seq_flag         = 1'b0;
    controller_req_sent_flag      = 1'b0;
    controller_inc_time_out_retry = 1'b0;
    rthr                          = 5'd4;
    ithr                          = 5'd2;
    tmax                          = 13'd8;
    repeat (2) @(posedge i_clk);
    test_reset();
    test_normal_retry();
    test_timeout_rerequest();
    test_escalation_abort();
    test_ack_vs_timeout();
    test_reset_mid_reinit();
    test_zero_thresholds();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/retry_lrsm_ctrl.md
Name: retry_lrsm_ctrl

Overview:
Local Retry State Machine (LRSM) controller for the link-layer retry datapath.
- Sequences a local retry after a CRC error on a received flit: issues RETRY.Req, waits for RETRY.Ack or timeout, escalates to a physical-layer re-init, and finally declares link failure.
- Owns the NUM_RETRY, NUM_PHY_REINIT and timeout counters.
- Drives the request, reinit and failure controls toward the controller, packer and register file.
- Sits between the unpacker/controller flags and the retry buffer datapath.

Parameters:
- NUM_W, 5, width of the NUM_RETRY and NUM_PHY_REINIT counters and thresholds.
- TMO_W, 13, width of the timeout counter and of the max-transfers register.
- PL_ACTIVE, 4'h1, i_pl_state_sts encoding for physical layer Active.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; one clock; reset is synchronous and active-high.
- i_pl_lnk_up  in  1  physical link up.
- i_pl_state_sts  in  4  physical layer state.
- unpacker_valid_sig  in  1  received flit valid.
- unpacker_valid_crc  in  1  CRC good; qualified by unpacker_valid_sig.
- unpacker_ack_seq_flag  in  1  RETRY.Ack received; 1-cycle pulse.
- controller_req_sent_flag  in  1  RETRY.Req transmitted; 1-cycle pulse.
- controller_inc_time_out_retry  in  1  timeout tick.
- i_register_file_retry_threshold  in  NUM_W  maximum retries before reinit.
- i_register_file_reinit_threshold  in  NUM_W  maximum reinits before abort.
- i_register_file_retry_timeout_max_transfers  in  TMO_W  timeout limit.
- retry_send_req_seq  out  1  request the controller to send RETRY.Req.
- retry_phy_reinit_req  out  1  request a physical-layer re-init.
- retry_link_failure_sig  out  1  link failure; sticky.
- retry_stop_read  out  1  freeze retry buffer reads.
- retry_exist_retry_state  out  1  LRSM is outside NORMAL.
- retry_num_retry  out  NUM_W  NUM_RETRY counter.
- retry_num_phy_reinit  out  NUM_W  NUM_PHY_REINIT counter.
- Retry_Threshold_hit  out  1  1-cycle pulse.
- REINIT_Threshold_hit  out  1  1-cycle pulse.
- LRSM  out  4  current state encoding.

Behaviour:
Reset
- All outputs are 0; LRSM = NORMAL (4'd0); all counters are 0.
- Reset asserted mid-operation returns the block to NORMAL on the next edge and clears the sticky failure.

States (4-bit codes): NORMAL = 0, LLRREQ = 1, IDLE = 2, PHY_REINIT = 3, ABORT = 4. All other codes go to NORMAL.

Definitions
- crc_err = unpacker_valid_sig & ~unpacker_valid_crc.

Transitions
- NORMAL:
  - crc_err -> LLRREQ on the next edge.
  - unpacker_ack_seq_flag alone is ignored.
- LLRREQ, evaluated in priority order:
  - (a) num_retry == retry_threshold and num_phy_reinit == reinit_threshold -> ABORT, with 1-cycle REINIT_Threshold_hit.
  - (b) num_retry == retry_threshold -> PHY_REINIT, with 1-cycle Retry_Threshold_hit.
  - (c) otherwise hold retry_send_req_seq = 1. On controller_req_sent_flag: num_retry += 1, clear the timeout counter, go to IDLE. retry_send_req_seq drops in the same cycle the state leaves LLRREQ.
- IDLE:
  - The timeout counter increments on controller_inc_time_out_retry and saturates at the all-ones value.
  - unpacker_ack_seq_flag -> NORMAL; clear num_retry and num_phy_reinit.
  - Else, counter == max_transfers -> LLRREQ.
  - An ack and a timeout in the same cycle: the ack wins.
  - crc_err in IDLE causes no transition.
- PHY_REINIT:
  - Hold retry_phy_reinit_req = 1.
  - On entry cycle: num_phy_reinit += 1 and num_retry is cleared.
  - Exit to LLRREQ once i_pl_lnk_up = 0 has been seen at least once and then i_pl_lnk_up = 1 with i_pl_state_sts == PL_ACTIVE. A 1-bit "down seen" flag tracks this and is cleared on entry.
- ABORT:
  - retry_link_failure_sig = 1; state is terminal until i_rst.

Output decode
- retry_stop_read = 1 in LLRREQ, IDLE and PHY_REINIT.
- retry_exist_retry_state = 1 whenever state != NORMAL.
- All outputs are registered or decoded from state registers; there is no combinational path from inputs to outputs.

Counter rules
- Counters are NUM_W bits and never wrap. Increments are blocked when a counter is at its maximum value.
- Threshold 0 means: first entry to LLRREQ goes directly to PHY_REINIT, or to ABORT if both thresholds are 0.

Latency
- CRC error to retry_send_req_seq high: 1 cycle.

Decomposition:
Shared package retry_pkg holds:
- lrsm_state_e enum (4-bit) with the state codes above.
- PL_ACTIVE constant.
- NUM_W and TMO_W defaults.

One sub-module, retry_timeout_cnt:
- Saturating TMO_W counter with clear, increment enable and an "== limit" compare output.
- Instantiated once.

Test Plan:
1. Normal retry: thresholds 4/2, max = 8. Inject crc_err, pulse req_sent, then pulse ack after 3 ticks.
   -> LRSM 0->1->2->0; retry_send_req_seq high exactly 1 cycle after crc_err; num_retry reads 1 in IDLE and 0 after the ack.
2. Timeout re-request: max = 3. Give 3 ticks and no ack.
   -> returns to LLRREQ; after a second req_sent, num_retry = 2.
3. Retry escalation: retry_threshold = 2, reinit_threshold = 1. Give two timeouts.
   -> Retry_Threshold_hit pulses once; PHY_REINIT with num_phy_reinit = 1 and num_retry = 0. Then lnk_up 1->0->1 with sts = 4'h1 -> LLRREQ.
4. Abort: continue scenario 3 with two more timeouts.
   -> REINIT_Threshold_hit pulses once; LRSM = 4; retry_link_failure_sig stays high while ack and crc_err are applied; i_rst clears it.
5. Simultaneous events: in IDLE, ack and the timeout-limit tick in the same cycle.
   -> NORMAL, not LLRREQ; counters cleared.
6. Reset mid-operation: assert i_rst while in PHY_REINIT.
   -> next edge: LRSM = 0 and all outputs 0; lnk_up held high without a drop does not exit PHY_REINIT on the next reinit.
